// File: rtl/serial_adder_8bit_pkg.sv
// Shared types and defaults for the bit-serial adder.
// Optional macro SERIAL_ADDER_OVERFLOW_EN is consumed by the interface and top.
package serial_adder_8bit_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_8bit_if.sv
// Start/done handshake and operand/result bus of the bit-serial adder.
// SERIAL_ADDER_OVERFLOW_EN adds the signed overflow flag.
interface serial_adder_8bit_if
  import serial_adder_8bit_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             carry_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic             overflow;
`endif

  modport master (
    output start, A, B, carry_in,
`ifdef SERIAL_ADDER_OVERFLOW_EN
    input  overflow,
`endif
    input  busy, done, result, carry_out
  );

  modport slave (
    input  start, A, B, carry_in,
`ifdef SERIAL_ADDER_OVERFLOW_EN
    output overflow,
`endif
    output busy, done, result, carry_out
  );

endinterface

// File: rtl/serial_adder_8bit_full_adder_1bit.sv
// One-bit full adder used as the single arithmetic cell of the serial datapath.
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_8bit.sv
// Bit-serial adder: one bit per clock, LSB first, single carry flop.
// Define SERIAL_ADDER_OVERFLOW_EN to add the registered signed overflow output.
module serial_adder_8bit
  import serial_adder_8bit_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input logic               clk,
  input logic               rst_n,
  serial_adder_8bit_if.slave bus
);

  localparam int unsigned     CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_nx;
  logic             busy, done;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr, result_q;
  logic             carry_q, carry_out_q;
  logic [CNT_W-1:0] cnt;
  logic             fa_s, fa_cout;
  logic             last_bit;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic             overflow_q;
`endif

  assign last_bit = (cnt == LAST);

  full_adder_1bit u_fa (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .cin (carry_q),
    .s   (fa_s),
    .cout(fa_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      ST_IDLE:  if (bus.start) state_nx = ST_SHIFT;
      ST_SHIFT: begin
        busy = 1'b1;
        if (last_bit) state_nx = ST_DONE;
      end
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr        <= '0;
      b_sr        <= '0;
      sum_sr      <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      cnt         <= '0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      overflow_q  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            a_sr    <= bus.A;
            b_sr    <= bus.B;
            carry_q <= bus.carry_in;
            cnt     <= '0;
          end
        end
        ST_SHIFT: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          sum_sr  <= {fa_s, sum_sr[WIDTH-1:1]};
          carry_q <= fa_cout;
          cnt     <= cnt + CNT_W'(1);
          // Final bit: capture the sum including the bit being produced now
          if (last_bit) begin
            result_q    <= {fa_s, sum_sr[WIDTH-1:1]};
            carry_out_q <= fa_cout;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            overflow_q  <= carry_q ^ fa_cout;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.result    = result_q;
  assign bus.carry_out = carry_out_q;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  assign bus.overflow  = overflow_q;
`endif

endmodule
